// File: rtl/nonce_dispatcher_pkg.sv
// Shared miner package: FSM state encoding, nonce widths and default latency.
package nonce_dispatcher_pkg;

  localparam int unsigned NONCE_W         = 32;
  // One extra bit so a full 2^32 nonce space terminates without wrapping.
  localparam int unsigned CNT_W           = NONCE_W + 1;
  localparam int unsigned LATENCY_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/nonce_dispatcher_if.sv
// Job handshake, round issue bus and completion signals between the dispatcher and its environment.
interface nonce_dispatcher_if
  import nonce_dispatcher_pkg::*;
#(
  parameter int unsigned NUMPROCESSORS = 10
);

  logic                     job_valid_i;
  logic                     job_ready_o;
  logic                     stall_i;
  logic                     found_i;
  logic                     valid_o;
  logic                     newblock_o;
  logic [NONCE_W-1:0]       base_o;
  logic [NUMPROCESSORS-1:0] lane_mask_o;
  logic                     done_o;
  logic                     found_o;

  // Dispatcher side.
  modport master (
    input  job_valid_i, stall_i, found_i,
    output job_ready_o, valid_o, newblock_o, base_o, lane_mask_o, done_o, found_o
  );

  // Job source / lane side.
  modport slave (
    output job_valid_i, stall_i, found_i,
    input  job_ready_o, valid_o, newblock_o, base_o, lane_mask_o, done_o, found_o
  );

endinterface

// File: rtl/nonce_dispatcher_lane_mask_gen.sv
// Combinational lane-enable mask: lane k is active while base+k is still inside the nonce space.
module lane_mask_gen
  import nonce_dispatcher_pkg::*;
#(
  parameter int unsigned NUMPROCESSORS = 10,
  parameter int unsigned IDXW          = $clog2(NUMPROCESSORS)
) (
  input  logic [CNT_W-1:0]         base,
  input  logic [CNT_W-1:0]         space,
  output logic [NUMPROCESSORS-1:0] mask_c
);

  localparam int unsigned LANE_W = IDXW + 1;

  // One comparator per lane, evaluated in the widened counter domain.
  for (genvar k = 0; k < NUMPROCESSORS; k++) begin : g_lane
    localparam logic [LANE_W-1:0] LANE = LANE_W'(k);
    assign mask_c[k] = (base + CNT_W'(LANE)) < space;
  end

endmodule

// File: rtl/nonce_dispatcher.sv
// Splits a block job's nonce space into rounds of NUMPROCESSORS lanes and reports completion.
module nonce_dispatcher
  import nonce_dispatcher_pkg::*;
#(
  parameter int unsigned      NUMPROCESSORS = 10,
  parameter logic [CNT_W-1:0] NONCESPACE    = CNT_W'(1024),
  parameter int unsigned      LATENCY       = LATENCY_DEFAULT,
  parameter int unsigned      PARTITIONBITS = $clog2(NUMPROCESSORS)
) (
  input  logic               clk,
  input  logic               rst,
  nonce_dispatcher_if.master bus
);

  localparam int unsigned      DRAIN_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [CNT_W-1:0] STEP    = CNT_W'(NUMPROCESSORS);

  state_e                   state;
  logic [CNT_W-1:0]         counter;
  logic [DRAIN_W-1:0]       drain_cnt;
  logic                     first_round;
  logic [NUMPROCESSORS-1:0] mask_c;
  logic [CNT_W-1:0]         next_counter_c;

  // Base of the round after the one about to issue; decides when the space is covered.
  assign next_counter_c = counter + STEP;

  lane_mask_gen #(
    .NUMPROCESSORS (NUMPROCESSORS),
    .IDXW          (PARTITIONBITS)
  ) u_lane_mask_gen (
    .base   (counter),
    .space  (NONCESPACE),
    .mask_c (mask_c)
  );

  // Job FSM with registered round and completion outputs; found_i takes priority over issuing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= ST_IDLE;
      counter         <= '0;
      drain_cnt       <= '0;
      first_round     <= 1'b0;
      bus.job_ready_o <= 1'b1;
      bus.valid_o     <= 1'b0;
      bus.newblock_o  <= 1'b0;
      bus.base_o      <= '0;
      bus.lane_mask_o <= '0;
      bus.done_o      <= 1'b0;
      bus.found_o     <= 1'b0;
    end else begin
      bus.valid_o    <= 1'b0;
      bus.newblock_o <= 1'b0;
      bus.done_o     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.job_valid_i) begin
            state           <= ST_ISSUE;
            counter         <= '0;
            first_round     <= 1'b1;
            bus.job_ready_o <= 1'b0;
          end
        end
        ST_ISSUE: begin
          if (bus.found_i) begin
            state       <= ST_DONE;
            bus.done_o  <= 1'b1;
            bus.found_o <= 1'b1;
          end else if (!bus.stall_i) begin
            bus.valid_o     <= 1'b1;
            bus.newblock_o  <= first_round;
            bus.base_o      <= counter[NONCE_W-1:0];
            bus.lane_mask_o <= mask_c;
            first_round     <= 1'b0;
            counter         <= next_counter_c;
            if (next_counter_c >= NONCESPACE) begin
              state     <= ST_DRAIN;
              drain_cnt <= DRAIN_W'(LATENCY);
            end
          end
        end
        ST_DRAIN: begin
          if (bus.found_i) begin
            state       <= ST_DONE;
            bus.done_o  <= 1'b1;
            bus.found_o <= 1'b1;
          end else if (drain_cnt <= DRAIN_W'(1)) begin
            state       <= ST_DONE;
            drain_cnt   <= '0;
            bus.done_o  <= 1'b1;
            bus.found_o <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt - DRAIN_W'(1);
          end
        end
        ST_DONE: begin
          state           <= ST_IDLE;
          bus.job_ready_o <= 1'b1;
        end
        default: begin
          state           <= ST_IDLE;
          bus.job_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/nonce_dispatcher.md
NONCE_DISPATCHER -- requirements
Module: nonce_dispatcher

Interface
REQ-001 Parameter NUMPROCESSORS, default 10, number of parallel hash lanes.
REQ-002 Parameter NONCESPACE, default 1024, nonces searched per job, range 1..2^32.
REQ-003 Parameter LATENCY, default 4, cycles from round issue to last possible found_i for that round.
REQ-004 Parameter PARTITIONBITS, default $clog2(NUMPROCESSORS), lane index width.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 job_valid_i  in  1  new block job offered.
REQ-008 job_ready_o  out  1  dispatcher can accept a job.
REQ-009 stall_i  in  1  lanes cannot take a round this cycle.
REQ-010 found_i  in  1  success reported by the nonce extractor.
REQ-011 valid_o  out  1  round issued; base_o and lane_mask_o are meaningful.
REQ-012 newblock_o  out  1  marks the first round of a job; lanes clear state.
REQ-013 base_o  out  32  nonce of lane 0; lane k hashes base_o+k.
REQ-014 lane_mask_o  out  NUMPROCESSORS  bit k set = lane k active this round.
REQ-015 done_o  out  1  one-cycle job-complete pulse.
REQ-016 found_o  out  1  qualified by done_o: 1 = success, 0 = nonce space exhausted.

Function
REQ-017 FSM states IDLE, ISSUE, DRAIN, DONE; job_ready_o SHALL be 1 only in IDLE.
REQ-018 IDLE: job_valid_i=1 -> accept job, clear issue counter to 0, go to ISSUE; otherwise stay.
REQ-019 ISSUE, stall_i=0, found_i=0: issue one round; on the next edge valid_o=1, base_o=counter, lane_mask_o per REQ-021, then counter += NUMPROCESSORS.
REQ-020 newblock_o SHALL be 1 only with the first valid_o after acceptance, including when that round was delayed by stall_i.
REQ-021 lane_mask_o bit k = (counter+k < NONCESPACE); full rounds all ones; the final partial round masks excess lanes.
REQ-022 Counter comparisons SHALL use 33-bit arithmetic so NONCESPACE=2^32 terminates without wrap.
REQ-023 stall_i=1 in ISSUE: no round, counter held, valid_o=0 next cycle.
REQ-024 After issuing the round for which counter+NUMPROCESSORS >= NONCESPACE, go to DRAIN and load a drain counter with LATENCY.
REQ-025 DRAIN: decrement each cycle; at zero with found_i=0 -> DONE with found_o=0.
REQ-026 found_i=1 in ISSUE or DRAIN -> DONE with found_o=1; no round issued that cycle, including when stall_i=0 simultaneously.
REQ-027 found_i in IDLE or DONE SHALL be ignored.
REQ-028 DONE: done_o=1 for exactly one cycle, then IDLE; job_valid_i there is not accepted until IDLE.
REQ-029 valid_o, newblock_o, base_o, lane_mask_o, done_o, found_o SHALL be registered outputs.
REQ-030 valid_o=0 outside the cycle following an issuing cycle; base_o and lane_mask_o hold their last values otherwise.

Reset
REQ-031 rst low SHALL asynchronously force IDLE, counters 0, valid_o=0, newblock_o=0, base_o=0, lane_mask_o=0, done_o=0, found_o=0.
REQ-032 Reset mid-ISSUE or mid-DRAIN SHALL abandon the job with no done_o pulse; job_ready_o=1 in the first cycle after release.

Structure
REQ-033 State enum typedef and the LATENCY default SHALL reside in the shared miner package.
REQ-034 Lane-mask generation SHALL be one sub-module, lane_mask_gen, combinational, parameterised by NUMPROCESSORS.

Verification
REQ-035 N=10, SPACE=25, LAT=4, no stall: rounds base 0/10/20, masks 0x3FF/0x3FF/0x01F, newblock only on first; done_o=1, found_o=0 four cycles after last round.
REQ-036 Same config, stall_i high for 3 cycles before the second round: three valid_o=0 gaps, bases unchanged, no duplicate or skipped base.
REQ-037 found_i pulsed the cycle after base 10 issues: no base 20 round, done_o=1 with found_o=1 next cycle.
REQ-038 found_i and job_valid_i both asserted in IDLE: job accepted, found ignored, base 0 issues with newblock_o=1.
REQ-039 rst low during DRAIN: outputs zero immediately, no done_o; a new job then starts at base 0 with newblock_o=1.
REQ-040 N=10, SPACE=10: single round mask 0x3FF, direct to DRAIN, done_o with found_o=0 after 4 cycles.
